// File: rtl/sel_mux_pkg.sv
// sel_mux_pkg: shared types for the sel_mux_rr channel selector.
//   mode_e : selection mode, MODE_MANUAL (select register) or MODE_RR
//            (round-robin scan of requesting channels).
package sel_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

endpackage : sel_mux_pkg

// File: rtl/sel_mux_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     : per-channel request vector
//   last    : index of the most recently granted channel
//   gnt_idx : first requesting channel at or after last+1 (wrapping modulo
//             CHANNELS); 0 when nothing requests
//   gnt_any : at least one channel requests
module rr_pick #(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                gnt_any
);

  // Offsets 1..CHANNELS from last; the final offset revisits last itself, so
  // a lone requester is still granted on consecutive cycles.
  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx = int'(unsigned'(last)) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule : rr_pick

// File: rtl/sel_mux_rr.sv
// sel_mux_rr: registered N:1 channel selector with a one-deep valid/ready
// output stage and manual or round-robin channel selection.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   ch_data, ch_valid   : packed per-channel data / requests
//   ch_ready            : per-channel accept strobe (one-hot or zero)
//   mode                : 0 manual (select register), 1 round-robin
//   sel_in, sel_load    : manual select value and its load strobe
//   sel_err, err_clr    : sticky out-of-range select flag and its clear
//   out_data, out_ch    : held word and the channel it came from
//   out_valid, out_ready: output handshake
module sel_mux_rr
  import sel_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic [CHANNELS-1:0]       ch_valid,
  output logic [CHANNELS-1:0]       ch_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  output logic                      sel_err,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  mode_e            mode_s;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [SEL_W-1:0] chosen;
  logic             chosen_valid;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] pick_data;
  logic             sel_bad;

  assign mode_s = mode_e'(mode);

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .req     (ch_valid),
    .last    (last_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  always_comb begin
    chosen       = sel_q;
    chosen_valid = ch_valid[sel_q];
    if (mode_s == MODE_RR) begin
      chosen       = rr_idx;
      chosen_valid = rr_any;
    end
  end

  assign slot_free = !out_valid || out_ready;
  // rst_n gating keeps every strobe low for the whole reset interval.
  assign accept    = rst_n && slot_free && chosen_valid;
  assign sel_bad   = sel_load && ({1'b0, sel_in} >= CH_LIM);

  always_comb begin
    ch_ready  = '0;
    pick_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (chosen == SEL_W'(i)) begin
        ch_ready[i] = accept;
        pick_data   = ch_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= pick_data;
      out_ch    <= chosen;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

  // last_q starts at the top channel so the first scan begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_CH;
    end else if (accept && mode_s == MODE_RR) begin
      last_q <= chosen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      sel_err <= 1'b0;
    end else begin
      if (sel_load && !sel_bad) sel_q <= sel_in;
      if (sel_bad)              sel_err <= 1'b1;
      else if (err_clr)         sel_err <= 1'b0;
    end
  end

endmodule : sel_mux_rr

// File: tb/tb_sel_mux_rr.sv
// tb_sel_mux_rr: self-checking bench for sel_mux_rr with a behavioural model.
module tb_sel_mux_rr;

  localparam int W  = 8;
  localparam int C  = 12;
  localparam int SW = $clog2(C);

  logic              clk;
  logic              rst_n;
  logic [C*W-1:0]    ch_data;
  logic [C-1:0]      ch_valid;
  logic [C-1:0]      ch_ready;
  logic              mode;
  logic [SW-1:0]     sel_in;
  logic              sel_load;
  logic              sel_err;
  logic              err_clr;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;

  sel_mux_rr #(
    .WIDTH    (W),
    .CHANNELS (C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .mode      (mode),
    .sel_in    (sel_in),
    .sel_load  (sel_load),
    .sel_err   (sel_err),
    .err_clr   (err_clr),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  int         m_sel;
  int         m_last;
  bit         m_v;
  logic [W-1:0] m_d;
  int         m_ch;
  bit         m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel  = 0;
    m_last = C - 1;
    m_v    = 1'b0;
    m_d    = '0;
    m_ch   = 0;
    m_err  = 1'b0;
  endtask

  // Channel the rules select this cycle, or -1 if none is eligible.
  function automatic int pick();
    if (mode == 1'b0) return ch_valid[m_sel] ? m_sel : -1;
    for (int k = 1; k <= C; k++) begin
      int idx;
      idx = (m_last + k) % C;
      if (ch_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check strobes before the edge, advance the model, check outputs after.
  task automatic tick();
    int c;
    bit slot;
    logic [C-1:0] er;
    #2;
    slot = !m_v || out_ready;
    c    = pick();
    er   = '0;
    if (slot && c >= 0) er[c] = 1'b1;
    chk("ch_ready", 64'(ch_ready), 64'(er));
    if (slot && c >= 0) begin
      m_v  = 1'b1;
      m_d  = ch_data[c*W +: W];
      m_ch = c;
      if (mode) m_last = c;
    end else if (slot) begin
      m_v = 1'b0;
    end
    if (sel_load && int'(sel_in) < C) m_sel = int'(sel_in);
    if (sel_load && int'(sel_in) >= C) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_v));
    chk("out_data",  64'(out_data),  64'(m_d));
    chk("out_ch",    64'(out_ch),    64'(m_ch));
    chk("sel_err",   64'(sel_err),   64'(m_err));
  endtask

  task automatic set_ramp_data();
    for (int i = 0; i < C; i++) ch_data[i*W +: W] = W'(i + 8'h10);
  endtask

  initial begin
    int seq [5];
    seq = '{2, 7, 11, 2, 7};
    rst_n = 1'b0; ch_data = '0; ch_valid = '0; mode = 1'b0;
    sel_in = '0; sel_load = 1'b0; err_clr = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_ch",    64'(out_ch),    64'd0);
    chk("rst_sel_err",   64'(sel_err),   64'd0);
    ch_valid = '1;
    #1;
    chk("rst_ch_ready",  64'(ch_ready),  64'd0);
    ch_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Manual select of channel 5
    sel_load = 1'b1; sel_in = SW'(5);
    tick();
    sel_load = 1'b0;
    ch_valid = '1; set_ramp_data(); out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("man_data",  64'(out_data), 64'h15);
      chk("man_ch",    64'(out_ch),   64'd5);
      chk("man_ready", 64'(ch_ready), 64'h020);
    end

    // Round-robin over {2,7,11} from the reset pointer, wrapping
    mode = 1'b1;
    ch_valid = '0; ch_valid[2] = 1'b1; ch_valid[7] = 1'b1; ch_valid[11] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq_ch",   64'(out_ch),   64'(seq[i]));
      chk("rr_seq_data", 64'(out_data), 64'(seq[i] + 16));
    end

    // Backpressure holds the word and freezes the pointer
    tick();
    chk("rr_next_ch", 64'(out_ch), 64'd11);
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("hold_ch",    64'(out_ch),    64'd11);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(ch_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 64'(ch_ready), 64'h004);
    tick();
    chk("release_ch", 64'(out_ch), 64'd2);

    // Out-of-range select load
    mode = 1'b0; ch_valid = '1;
    sel_load = 1'b1; sel_in = SW'(14);
    tick();
    sel_load = 1'b0;
    chk("bad_load_err", 64'(sel_err), 64'd1);
    tick();
    chk("bad_load_sel_kept", 64'(out_ch), 64'd5);
    sel_load = 1'b1; sel_in = SW'(14); err_clr = 1'b1;
    tick();
    chk("err_set_wins", 64'(sel_err), 64'd1);
    sel_load = 1'b0;
    tick();
    chk("err_cleared", 64'(sel_err), 64'd0);
    err_clr = 1'b0;

    // Selected channel idle while others request
    ch_valid = '1; ch_valid[5] = 1'b0;
    tick();
    chk("idle_sel_valid", 64'(out_valid), 64'd0);
    chk("idle_sel_ready", 64'(ch_ready),  64'd0);

    // Asynchronous reset while a word is held
    ch_valid = '1; out_ready = 1'b0;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data",  64'(out_data),  64'd0);
    chk("async_rst_ready", 64'(ch_ready),  64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode = 1'b1; out_ready = 1'b1;
    ch_valid = '0; ch_valid[4] = 1'b1; ch_valid[9] = 1'b1;
    tick();
    chk("post_rst_first_rr", 64'(out_ch), 64'd4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < C; i++) ch_data[i*W +: W] = W'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      ch_valid  = C'($urandom) & ((n % 3 == 0) ? C'($urandom) : '1);
      out_ready = ($urandom_range(0, 3) != 0);
      sel_load  = ($urandom_range(0, 7) == 0);
      sel_in    = SW'($urandom_range(0, 15));
      err_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sel_mux_rr
